// File: rtl/kbd_arrow_decoder_pkg.sv
// Shared scan-code constants, FSM state types and helpers for the PS/2 arrow-key decoder.
package kbd_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_OVR0  = 8'h00;
    localparam logic [7:0] SC_OVRF  = 8'hFF;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;

    localparam logic [2:0] KEY_LEFT  = 3'd0;
    localparam logic [2:0] KEY_RIGHT = 3'd1;
    localparam logic [2:0] KEY_UP    = 3'd2;
    localparam logic [2:0] KEY_DOWN  = 3'd3;
    localparam logic [2:0] KEY_A     = 3'd4;
    localparam logic [2:0] KEY_D     = 3'd5;
    localparam logic [2:0] KEY_W     = 3'd6;
    localparam logic [2:0] KEY_S     = 3'd7;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        CODE_BASE   = 2'd0,
        CODE_EXT    = 2'd1,
        CODE_BRK    = 2'd2,
        CODE_EXTBRK = 2'd3
    } code_state_t;

    // True when data plus parity bit carry an odd number of ones.
    function automatic logic oddParityOk(input logic [7:0] data, input logic parity);
        return ^{parity, data};
    endfunction

    // Returns {hit, keyIndex} for a {extended, byte} code.
    function automatic logic [3:0] keyLookup(input logic [8:0] code);
        logic [3:0] res;
        case (code)
            {1'b1, SC_LEFT}:  res = {1'b1, KEY_LEFT};
            {1'b1, SC_RIGHT}: res = {1'b1, KEY_RIGHT};
            {1'b1, SC_UP}:    res = {1'b1, KEY_UP};
            {1'b1, SC_DOWN}:  res = {1'b1, KEY_DOWN};
            {1'b0, SC_A}:     res = {1'b1, KEY_A};
            {1'b0, SC_D}:     res = {1'b1, KEY_D};
            {1'b0, SC_W}:     res = {1'b1, KEY_W};
            {1'b0, SC_S}:     res = {1'b1, KEY_S};
            default:          res = 4'b0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/kbd_arrow_decoder_if.sv
// Keyboard pins plus decoded key outputs; slave is the decoder, master is the board/consumer side.
interface kbd_arrow_decoder_if;
    logic       kbdClk;
    logic       kbdDat;
    logic       leftPressed;
    logic       rightPressed;
    logic       upPressed;
    logic       downPressed;
    logic [8:0] keyCode;
    logic       makePulse;
    logic       breakPulse;
    logic       frameError;

    modport master (
        output kbdClk, kbdDat,
        input  leftPressed, rightPressed, upPressed, downPressed,
        input  keyCode, makePulse, breakPulse, frameError
    );

    modport slave (
        input  kbdClk, kbdDat,
        output leftPressed, rightPressed, upPressed, downPressed,
        output keyCode, makePulse, breakPulse, frameError
    );
endinterface

// File: rtl/kbd_arrow_decoder_ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, 11-bit frame FSM with
// odd-parity/stop check and an in-frame inactivity timeout.
module ps2_frame_rx
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       kbdClk,
    input  logic       kbdDat,
    output logic       byteValid,
    output logic [7:0] byteData,
    output logic       frameError
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       clkSync_r;
    logic [1:0]       datSync_r;
    logic             clkPrev_r;
    logic             fallEdge_s;
    logic             datBit_s;
    logic             timeoutHit_s;

    rx_state_t        state_r;
    rx_state_t        stateNext_s;
    logic [2:0]       bitCnt_r;
    logic [2:0]       bitCntNext_s;
    logic [7:0]       shift_r;
    logic [7:0]       shiftNext_s;
    logic             parity_r;
    logic             parityNext_s;
    logic             acceptNext_s;
    logic             errNext_s;
    logic [CNT_W-1:0] timeoutCnt_r;

    logic             byteValid_r;
    logic [7:0]       byteData_r;
    logic             frameError_r;

    // Two-flop synchronizers, reset to the idle-high bus level, plus the edge-detect history flop.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            clkSync_r <= 2'b11;
            datSync_r <= 2'b11;
            clkPrev_r <= 1'b1;
        end else begin
            clkSync_r <= {clkSync_r[0], kbdClk};
            datSync_r <= {datSync_r[0], kbdDat};
            clkPrev_r <= clkSync_r[1];
        end
    end

    assign fallEdge_s   = clkPrev_r & ~clkSync_r[1];
    assign datBit_s     = datSync_r[1];
    assign timeoutHit_s = (state_r != RX_IDLE) && !fallEdge_s && (timeoutCnt_r == CNT_LAST);

    // Frame FSM next-state: one bit consumed per falling edge; timeout overrides everything.
    always_comb begin
        stateNext_s  = state_r;
        bitCntNext_s = bitCnt_r;
        shiftNext_s  = shift_r;
        parityNext_s = parity_r;
        acceptNext_s = 1'b0;
        errNext_s    = 1'b0;
        if (timeoutHit_s) begin
            stateNext_s = RX_IDLE;
            errNext_s   = 1'b1;
        end else if (fallEdge_s) begin
            case (state_r)
                RX_IDLE: begin
                    if (!datBit_s) begin
                        stateNext_s  = RX_DATA;
                        bitCntNext_s = 3'd0;
                    end else begin
                        stateNext_s = RX_IDLE;
                    end
                end
                RX_DATA: begin
                    shiftNext_s  = {datBit_s, shift_r[7:1]};
                    bitCntNext_s = bitCnt_r + 3'd1;
                    if (bitCnt_r == 3'd7) begin
                        stateNext_s = RX_PARITY;
                    end else begin
                        stateNext_s = RX_DATA;
                    end
                end
                RX_PARITY: begin
                    parityNext_s = datBit_s;
                    stateNext_s  = RX_STOP;
                end
                RX_STOP: begin
                    stateNext_s = RX_IDLE;
                    if (datBit_s && oddParityOk(shift_r, parity_r)) begin
                        acceptNext_s = 1'b1;
                    end else begin
                        errNext_s = 1'b1;
                    end
                end
                default: stateNext_s = RX_IDLE;
            endcase
        end else begin
            stateNext_s = state_r;
        end
    end

    // Frame state, shift register and registered byte/error outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r      <= RX_IDLE;
            bitCnt_r     <= 3'd0;
            shift_r      <= 8'h00;
            parity_r     <= 1'b0;
            byteValid_r  <= 1'b0;
            byteData_r   <= 8'h00;
            frameError_r <= 1'b0;
        end else begin
            state_r      <= stateNext_s;
            bitCnt_r     <= bitCntNext_s;
            shift_r      <= shiftNext_s;
            parity_r     <= parityNext_s;
            byteValid_r  <= acceptNext_s;
            frameError_r <= errNext_s;
            if (acceptNext_s) begin
                byteData_r <= shift_r;
            end
        end
    end

    // Inactivity counter: idle in IDLE, restarted by every falling edge inside a frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            timeoutCnt_r <= '0;
        end else if ((state_r == RX_IDLE) || fallEdge_s || timeoutHit_s) begin
            timeoutCnt_r <= '0;
        end else begin
            timeoutCnt_r <= timeoutCnt_r + CNT_W'(1);
        end
    end

    assign byteValid  = byteValid_r;
    assign byteData   = byteData_r;
    assign frameError = frameError_r;

endmodule

// File: rtl/kbd_arrow_decoder.sv
// Set-2 scan-code decoder: E0/F0 prefix FSM, per-key held bits and direction OR mapping.
module kbd_arrow_decoder
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                resetN,
    kbd_arrow_decoder_if.slave  bus
);

    logic        byteValid_s;
    logic [7:0]  byteData_s;
    logic        frameError_s;

    code_state_t code_r;
    code_state_t codeNext_s;
    logic [7:0]  held_r;
    logic [7:0]  heldNext_s;
    logic        evMake_s;
    logic        evBreak_s;
    logic [8:0]  evCode_s;
    logic [3:0]  lookup_s;
    logic [7:0]  keyMask_s;

    logic [8:0]  keyCode_r;
    logic        makePulse_r;
    logic        breakPulse_r;
    logic        leftPressed_r;
    logic        rightPressed_r;
    logic        upPressed_r;
    logic        downPressed_r;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .resetN    (resetN),
        .kbdClk    (bus.kbdClk),
        .kbdDat    (bus.kbdDat),
        .byteValid (byteValid_s),
        .byteData  (byteData_s),
        .frameError(frameError_s)
    );

    // Prefix FSM and held-bit update for each accepted byte.
    always_comb begin
        codeNext_s = code_r;
        heldNext_s = held_r;
        evMake_s   = 1'b0;
        evBreak_s  = 1'b0;
        evCode_s   = keyCode_r;
        if (byteValid_s) begin
            case (code_r)
                CODE_BASE: begin
                    if (byteData_s == SC_EXT) begin
                        codeNext_s = CODE_EXT;
                    end else if (byteData_s == SC_BRK) begin
                        codeNext_s = CODE_BRK;
                    end else if ((byteData_s == SC_OVR0) || (byteData_s == SC_OVRF)) begin
                        heldNext_s = 8'h00;
                    end else begin
                        evMake_s = 1'b1;
                        evCode_s = {1'b0, byteData_s};
                    end
                end
                CODE_EXT: begin
                    if (byteData_s == SC_BRK) begin
                        codeNext_s = CODE_EXTBRK;
                    end else begin
                        evMake_s   = 1'b1;
                        evCode_s   = {1'b1, byteData_s};
                        codeNext_s = CODE_BASE;
                    end
                end
                CODE_BRK: begin
                    evBreak_s  = 1'b1;
                    evCode_s   = {1'b0, byteData_s};
                    codeNext_s = CODE_BASE;
                end
                CODE_EXTBRK: begin
                    evBreak_s  = 1'b1;
                    evCode_s   = {1'b1, byteData_s};
                    codeNext_s = CODE_BASE;
                end
                default: codeNext_s = CODE_BASE;
            endcase
        end else begin
            codeNext_s = code_r;
        end
    end

    assign lookup_s  = keyLookup(evCode_s);
    assign keyMask_s = lookup_s[3] ? (8'h01 << lookup_s[2:0]) : 8'h00;

    // Held bits, event outputs and direction levels all update together.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            code_r         <= CODE_BASE;
            held_r         <= 8'h00;
            keyCode_r      <= 9'h000;
            makePulse_r    <= 1'b0;
            breakPulse_r   <= 1'b0;
            leftPressed_r  <= 1'b0;
            rightPressed_r <= 1'b0;
            upPressed_r    <= 1'b0;
            downPressed_r  <= 1'b0;
        end else begin
            code_r         <= codeNext_s;
            held_r         <= heldNext_s | (evMake_s ? keyMask_s : 8'h00);
            if (evBreak_s) begin
                held_r <= heldNext_s & ~keyMask_s;
            end
            keyCode_r      <= evCode_s;
            makePulse_r    <= evMake_s;
            breakPulse_r   <= evBreak_s;
            leftPressed_r  <= nextHeld(KEY_LEFT)  | nextHeld(KEY_A);
            rightPressed_r <= nextHeld(KEY_RIGHT) | nextHeld(KEY_D);
            upPressed_r    <= nextHeld(KEY_UP)    | nextHeld(KEY_W);
            downPressed_r  <= nextHeld(KEY_DOWN)  | nextHeld(KEY_S);
        end
    end

    // Held value after this cycle's make/break, looked up per key index.
    function automatic logic nextHeld(input logic [2:0] idx);
        logic [7:0] h;
        h = heldNext_s;
        if (evMake_s) begin
            h = h | keyMask_s;
        end else if (evBreak_s) begin
            h = h & ~keyMask_s;
        end else begin
            h = heldNext_s;
        end
        return h[idx];
    endfunction

    assign bus.leftPressed  = leftPressed_r;
    assign bus.rightPressed = rightPressed_r;
    assign bus.upPressed    = upPressed_r;
    assign bus.downPressed  = downPressed_r;
    assign bus.keyCode      = keyCode_r;
    assign bus.makePulse    = makePulse_r;
    assign bus.breakPulse   = breakPulse_r;
    assign bus.frameError   = frameError_s;

endmodule

// File: tb/tb_kbd_arrow_decoder.sv
// Scoreboard bench: directed PS/2 frames push expected events; a monitor pops and compares.
module tb_kbd_arrow_decoder;

    localparam int TO = 300;
    localparam int H  = 10;

    localparam int EV_MAKE  = 0;
    localparam int EV_BREAK = 1;
    localparam int EV_ERR   = 2;

    typedef struct {
        int         kind;
        logic [8:0] code;
        logic [3:0] pressed;
    } exp_t;

    logic clk;
    logic resetN;
    int   tests;
    int   failed;
    exp_t expQ[$];
    exp_t e;

    kbd_arrow_decoder_if kbdIf ();

    kbd_arrow_decoder #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (kbdIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] pressedNow();
        return {kbdIf.leftPressed, kbdIf.rightPressed, kbdIf.upPressed, kbdIf.downPressed};
    endfunction

    // Monitor: every output pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (resetN && (kbdIf.makePulse || kbdIf.breakPulse || kbdIf.frameError)) begin
            int gotKind;
            if (32'(kbdIf.makePulse) + 32'(kbdIf.breakPulse) + 32'(kbdIf.frameError) != 1)
                gotKind = 3;
            else if (kbdIf.frameError)
                gotKind = EV_ERR;
            else if (kbdIf.breakPulse)
                gotKind = EV_BREAK;
            else
                gotKind = EV_MAKE;
            tests++;
            if (expQ.size() == 0) begin
                failed++;
                $display("FAIL unexpected_event kind=%0d code=%h pressed=%b", gotKind, kbdIf.keyCode, pressedNow());
            end else begin
                e = expQ.pop_front();
                if (gotKind != e.kind || (e.kind != EV_ERR && kbdIf.keyCode != e.code) ||
                    pressedNow() != e.pressed) begin
                    failed++;
                    $display("FAIL event got kind=%0d code=%h pressed=%b expected kind=%0d code=%h pressed=%b",
                             gotKind, kbdIf.keyCode, pressedNow(), e.kind, e.code, e.pressed);
                end
            end
        end
    end

    task automatic expectEv(input int kind, input logic [8:0] code, input logic [3:0] pressed);
        exp_t x;
        x.kind = kind;
        x.code = code;
        x.pressed = pressed;
        expQ.push_back(x);
    endtask

    task automatic ps2Bit(input logic b);
        kbdIf.kbdDat = b;
        repeat (H) @(negedge clk);
        kbdIf.kbdClk = 1'b0;
        repeat (H) @(negedge clk);
        kbdIf.kbdClk = 1'b1;
    endtask

    task automatic sendFrame(input logic [7:0] d, input logic badPar, input logic badStop);
        ps2Bit(1'b0);
        for (int i = 0; i < 8; i++) ps2Bit(d[i]);
        ps2Bit((~^d) ^ badPar);
        ps2Bit(~badStop);
        kbdIf.kbdDat = 1'b1;
        repeat (2 * H) @(negedge clk);
    endtask

    task automatic sendOk(input logic [7:0] d);
        sendFrame(d, 1'b0, 1'b0);
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        tests++;
        if (expQ.size() != 0) begin
            failed++;
            $display("FAIL drain_%s pending=%0d required=0", name, expQ.size());
            expQ.delete();
        end
    endtask

    task automatic checkOut(input string name, input logic [3:0] expP, input logic [8:0] expC);
        @(negedge clk);
        tests++;
        if (pressedNow() != expP || kbdIf.keyCode != expC ||
            kbdIf.makePulse || kbdIf.breakPulse || kbdIf.frameError) begin
            failed++;
            $display("FAIL %s pressed=%b code=%h pulses=%b%b%b required pressed=%b code=%h pulses=000",
                     name, pressedNow(), kbdIf.keyCode, kbdIf.makePulse, kbdIf.breakPulse,
                     kbdIf.frameError, expP, expC);
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        resetN = 1'b0;
        kbdIf.kbdClk = 1'b1;
        kbdIf.kbdDat = 1'b1;
        repeat (5) @(negedge clk);
        checkOut("reset_state", 4'b0000, 9'h000);
        resetN = 1'b1;
        repeat (5) @(negedge clk);
        checkOut("after_reset", 4'b0000, 9'h000);

        // Left arrow make/break
        expectEv(EV_MAKE, 9'h16B, 4'b1000);
        sendOk(8'hE0); sendOk(8'h6B);
        expectEv(EV_BREAK, 9'h16B, 4'b0000);
        sendOk(8'hE0); sendOk(8'hF0); sendOk(8'h6B);
        waitDrain("left");

        // A and left share the left output
        expectEv(EV_MAKE, 9'h01C, 4'b1000);   sendOk(8'h1C);
        expectEv(EV_MAKE, 9'h16B, 4'b1000);   sendOk(8'hE0); sendOk(8'h6B);
        expectEv(EV_BREAK, 9'h01C, 4'b1000);  sendOk(8'hF0); sendOk(8'h1C);
        expectEv(EV_BREAK, 9'h16B, 4'b0000);  sendOk(8'hE0); sendOk(8'hF0); sendOk(8'h6B);
        waitDrain("a_left");

        // Typematic up
        for (int i = 0; i < 5; i++) begin
            expectEv(EV_MAKE, 9'h175, 4'b0010);
            sendOk(8'hE0); sendOk(8'h75);
        end
        expectEv(EV_BREAK, 9'h175, 4'b0000);
        sendOk(8'hE0); sendOk(8'hF0); sendOk(8'h75);
        waitDrain("typematic");

        // Bad parity then good D
        expectEv(EV_ERR, 9'h000, 4'b0000);    sendFrame(8'h23, 1'b1, 1'b0);
        expectEv(EV_MAKE, 9'h023, 4'b0100);   sendOk(8'h23);
        expectEv(EV_BREAK, 9'h023, 4'b0000);  sendOk(8'hF0); sendOk(8'h23);
        waitDrain("parity");

        // Bad stop bit
        expectEv(EV_ERR, 9'h000, 4'b0000);    sendFrame(8'h1B, 1'b0, 1'b1);
        waitDrain("stop");

        // Timeout after 4 data bits, then a clean down arrow
        expectEv(EV_ERR, 9'h000, 4'b0000);
        ps2Bit(1'b0); ps2Bit(1'b1); ps2Bit(1'b1); ps2Bit(1'b0); ps2Bit(1'b0);
        kbdIf.kbdDat = 1'b1;
        repeat (TO + 100) @(negedge clk);
        waitDrain("timeout");
        expectEv(EV_MAKE, 9'h172, 4'b0001);   sendOk(8'hE0); sendOk(8'h72);
        expectEv(EV_BREAK, 9'h172, 4'b0000);  sendOk(8'hE0); sendOk(8'hF0); sendOk(8'h72);
        waitDrain("down");

        // Opposite directions both held
        expectEv(EV_MAKE, 9'h16B, 4'b1000);   sendOk(8'hE0); sendOk(8'h6B);
        expectEv(EV_MAKE, 9'h174, 4'b1100);   sendOk(8'hE0); sendOk(8'h74);
        expectEv(EV_BREAK, 9'h174, 4'b1000);  sendOk(8'hE0); sendOk(8'hF0); sendOk(8'h74);
        expectEv(EV_BREAK, 9'h16B, 4'b0000);  sendOk(8'hE0); sendOk(8'hF0); sendOk(8'h6B);
        waitDrain("both");

        // Overrun FF clears held keys silently; unmapped AA changes no level
        expectEv(EV_MAKE, 9'h023, 4'b0100);   sendOk(8'h23);
        expectEv(EV_MAKE, 9'h01D, 4'b0110);   sendOk(8'h1D);
        waitDrain("dw");
        sendOk(8'hFF);
        waitDrain("ff");
        checkOut("after_ff", 4'b0000, 9'h01D);
        expectEv(EV_MAKE, 9'h0AA, 4'b0000);   sendOk(8'hAA);
        waitDrain("aa");

        // Reset mid-frame after E0 drops prefix and held keys
        expectEv(EV_MAKE, 9'h01D, 4'b0010);   sendOk(8'h1D);
        waitDrain("w_before_reset");
        sendOk(8'hE0);
        ps2Bit(1'b0); ps2Bit(1'b0); ps2Bit(1'b0);
        resetN = 1'b0;
        kbdIf.kbdClk = 1'b1;
        kbdIf.kbdDat = 1'b1;
        repeat (4) @(negedge clk);
        resetN = 1'b1;
        repeat (5) @(negedge clk);
        checkOut("mid_frame_reset", 4'b0000, 9'h000);
        expectEv(EV_MAKE, 9'h074, 4'b0000);   sendOk(8'h74);
        waitDrain("after_reset_74");
        checkOut("final", 4'b0000, 9'h074);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
